// File: rtl/sdram_pattern_tester.sv
// SDRAM pattern exerciser: writes a pattern window through the controller
// command FIFO, reads it back with pipelined reads and checks every word.
module sdram_pattern_tester #(
    parameter logic [23:0] BASE_ADDR       = 24'h001000,
    parameter int unsigned NUM_WORDS       = 256,
    parameter logic [23:0] ADDR_STRIDE     = 24'd1,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset_n_i,
    input  logic        start_i,
    input  logic        abort_i,
    input  logic [1:0]  mode_i,
    input  logic        loop_i,
    output logic [59:0] writer_d_o,
    output logic        writer_enq_o,
    input  logic        writer_full_i,
    input  logic [15:0] reader_q_i,
    output logic        reader_deq_o,
    input  logic        reader_empty_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        pass_o,
    output logic        error_o,
    output logic [15:0] err_count_o,
    output logic [23:0] first_err_addr_o,
    output logic [15:0] first_err_data_o,
    output logic [15:0] pass_count_o
);

    localparam int CW = 25;
    localparam logic [CW-1:0] NW = CW'(NUM_WORDS);
    localparam logic [3:0] MO = 4'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nx;

    logic [1:0]    mode;
    logic [CW-1:0] wr_cnt, rd_cnt, chk_cnt;
    logic [23:0]   wr_addr, rd_addr, chk_addr;
    logic [15:0]   wr_lfsr, chk_lfsr;
    logic [3:0]    outstanding;
    logic          chk_valid;
    logic          aborted;

    logic          can_cmd, wr_issue, rd_issue, deq_issue;
    logic          pass_end, start_ok, enter_write, enter_drain;
    logic          mismatch;
    logic [15:0]   chk_exp;

    // x^16+x^14+x^13+x^11+1, Fibonacci form shifting towards bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    function automatic logic [15:0] pattern(
        input logic [1:0]  m,
        input logic [23:0] a,
        input logic [3:0]  i,
        input logic [15:0] l
    );
        logic [15:0] p;
        unique case (m)
            2'd0:    p = a[15:0];
            2'd1:    p = l;
            2'd2:    p = 16'd1 << i;
            default: p = ~a[15:0];
        endcase
        return p;
    endfunction

    always_comb begin
        can_cmd   = !writer_full_i && !writer_enq_o && !abort_i;
        wr_issue  = (state == S_WRITE) && can_cmd && (wr_cnt < NW);
        rd_issue  = (state == S_READ) && can_cmd && (rd_cnt < NW)
                    && (outstanding < MO);
        deq_issue = (state == S_READ || state == S_DRAIN)
                    && !reader_empty_i && (outstanding != 4'd0)
                    && !reader_deq_o;
        pass_end  = (state == S_READ) && (chk_cnt == NW);
        start_ok  = start_i && (state == S_IDLE || state == S_DONE);
        chk_exp   = pattern(mode, chk_addr, chk_cnt[3:0], chk_lfsr);
        mismatch  = chk_valid && (reader_q_i != chk_exp);
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) state <= S_IDLE;
        else            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start_i) state_nx = S_WRITE;
            end
            S_WRITE: begin
                if (abort_i)           state_nx = S_DRAIN;
                else if (wr_cnt == NW) state_nx = S_READ;
            end
            S_READ: begin
                if (pass_end)
                    state_nx = (loop_i && !abort_i) ? S_WRITE : S_DONE;
                else if (abort_i)
                    state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                if (outstanding == 4'd0 && !reader_deq_o && !chk_valid)
                    state_nx = S_DONE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o  = (state == S_WRITE) || (state == S_READ)
                  || (state == S_DRAIN);
        done_o  = (state == S_DONE);
        pass_o  = (state == S_DONE) && (err_count_o == 16'd0) && !aborted;
        error_o = (err_count_o != 16'd0);
    end

    always_comb begin
        enter_write = (state_nx == S_WRITE) && (state != S_WRITE);
        enter_drain = (state_nx == S_DRAIN) && (state != S_DRAIN);
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            writer_d_o       <= '0;
            writer_enq_o     <= 1'b0;
            reader_deq_o     <= 1'b0;
            chk_valid        <= 1'b0;
            mode             <= 2'd0;
            wr_cnt           <= '0;
            rd_cnt           <= '0;
            chk_cnt          <= '0;
            wr_addr          <= '0;
            rd_addr          <= '0;
            chk_addr         <= '0;
            wr_lfsr          <= LFSR_SEED;
            chk_lfsr         <= LFSR_SEED;
            outstanding      <= 4'd0;
            aborted          <= 1'b0;
            err_count_o      <= 16'd0;
            first_err_addr_o <= 24'd0;
            first_err_data_o <= 16'd0;
            pass_count_o     <= 16'd0;
        end else begin
            writer_enq_o <= wr_issue || rd_issue;
            reader_deq_o <= deq_issue;
            chk_valid    <= reader_deq_o;

            if (wr_issue)
                writer_d_o <= {19'd0, 1'b1, wr_addr,
                               pattern(mode, wr_addr, wr_cnt[3:0], wr_lfsr)};
            else if (rd_issue)
                writer_d_o <= {19'd0, 1'b0, rd_addr, 16'd0};

            if (rd_issue && !deq_issue)
                outstanding <= outstanding + 4'd1;
            else if (!rd_issue && deq_issue)
                outstanding <= outstanding - 4'd1;

            if (wr_issue) begin
                wr_cnt  <= wr_cnt + CW'(1);
                wr_addr <= wr_addr + ADDR_STRIDE;
                wr_lfsr <= lfsr_next(wr_lfsr);
            end

            if (rd_issue) begin
                rd_cnt  <= rd_cnt + CW'(1);
                rd_addr <= rd_addr + ADDR_STRIDE;
            end

            if (chk_valid) begin
                chk_cnt  <= chk_cnt + CW'(1);
                chk_addr <= chk_addr + ADDR_STRIDE;
                chk_lfsr <= lfsr_next(chk_lfsr);
            end

            if (mismatch) begin
                if (err_count_o == 16'd0) begin
                    first_err_addr_o <= chk_addr;
                    first_err_data_o <= reader_q_i;
                end
                if (err_count_o != 16'hFFFF)
                    err_count_o <= err_count_o + 16'd1;
            end

            if (pass_end)
                pass_count_o <= pass_count_o + 16'd1;

            if (enter_drain)
                aborted <= 1'b1;

            if (enter_write) begin
                wr_cnt   <= '0;
                rd_cnt   <= '0;
                chk_cnt  <= '0;
                wr_addr  <= BASE_ADDR;
                rd_addr  <= BASE_ADDR;
                chk_addr <= BASE_ADDR;
            end

            // an aborted run leaves the checker behind the writer; realign
            if (start_ok) begin
                mode             <= mode_i;
                aborted          <= 1'b0;
                err_count_o      <= 16'd0;
                first_err_addr_o <= 24'd0;
                first_err_data_o <= 16'd0;
                pass_count_o     <= 16'd0;
                chk_lfsr         <= wr_lfsr;
            end
        end
    end

endmodule
